ifetch: RTL and testbench



---
 rtl/cpu32_pkg.sv | 19 +
 rtl/ifetch_if.sv | 26 ++
 rtl/fifo_sync.sv | 53 +++++
 rtl/ifetch.sv | 142 ++++++++++++++
 tb/tb_ifetch.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu32_pkg.sv
// Shared definitions for the cpu32 core: reset vector, word size, fetch FSM
// state encoding and the prefetch queue entry layout.
package cpu32_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam int          WORD_BYTES   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_if.sv
// Bus bundle between the fetch stage, instruction memory and the core.
// The master side is the fetch stage; the slave side is its environment.
interface ifetch_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ir_valid;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_ready;

  modport master (
    output mem_req, mem_addr, ir_valid, ir, ir_pc,
    input  mem_ack, mem_data, redirect, redirect_pc, ir_ready
  );

  modport slave (
    input  mem_req, mem_addr, ir_valid, ir, ir_pc,
    output mem_ack, mem_data, redirect, redirect_pc, ir_ready
  );

endinterface

// File: rtl/fifo_sync.sv
// Synchronous prefetch queue holding {pc, instr} entries. Flush empties the
// queue in one cycle; the head reads as zero while the queue is empty.
module fifo_sync
  import cpu32_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: issues one word read at a time, buffers results
// with their PCs in a prefetch queue and hands them to the core.
// Optional feature macro: IFETCH_BYPASS_EN (zero-latency path from memory to
// ir when the queue is empty).
module ifetch
  import cpu32_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
  input logic      clk,
  input logic      reset,
  ifetch_if.master bus
);

  localparam int          CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [31:0] ALIGN_MASK = ~32'(WORD_BYTES - 1);
  localparam logic [31:0] START_PC   = RESET_PC & ALIGN_MASK;

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   next_pc;
  logic [31:0]   target_pc;
  logic          mem_req_q;
  logic [31:0]   mem_addr_q;
  fetch_entry_t  q_head;
  fetch_entry_t  q_wdata;
  logic [CW-1:0] q_count;
  logic [CW-1:0] count_after;
  logic          q_empty;
  logic          q_full;
  logic          acked;
  logic          push;
  logic          pop;
  logic          bypass_valid;
  logic          bypass_take;

  assign target_pc = bus.redirect_pc & ALIGN_MASK;
  assign next_pc   = fetch_pc + 32'(WORD_BYTES);
  // Only an ack to a live request carries useful data; a DROP ack is stale.
  assign acked     = (state == REQ) && bus.mem_ack;

`ifdef IFETCH_BYPASS_EN
  assign bypass_valid = acked & q_empty & ~bus.redirect;
  assign bypass_take  = bypass_valid & bus.ir_ready;
`else
  assign bypass_valid = 1'b0;
  assign bypass_take  = 1'b0;
`endif

  // A redirect flushes the queue, so it overrides any same-cycle push or pop.
  assign push        = acked & ~bus.redirect & ~bypass_take;
  assign pop         = ~q_empty & bus.ir_ready & ~bus.redirect;
  assign q_wdata     = '{pc: fetch_pc, instr: bus.mem_data};
  assign count_after = q_count + CW'(push) - CW'(pop);

  fifo_sync #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .wdata (q_wdata),
    .head  (q_head),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

  // Core-facing outputs come from the queue head unless the bypass is active.
  always_comb begin
    bus.ir_valid = ~q_empty;
    bus.ir       = q_head.instr;
    bus.ir_pc    = q_head.pc;
    if (bypass_valid) begin
      bus.ir_valid = 1'b1;
      bus.ir       = bus.mem_data;
      bus.ir_pc    = fetch_pc;
    end
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;

  // Fetch FSM: one request in flight at most, issued only with a free slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fetch_pc   <= START_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= START_PC;
    end else begin
      case (state)
        IDLE: begin
          if (bus.redirect) begin
            fetch_pc   <= target_pc;
            state      <= REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= target_pc;
          end else if (!q_full) begin
            state      <= REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= fetch_pc;
          end
        end
        REQ: begin
          if (bus.redirect) begin
            fetch_pc <= target_pc;
            if (bus.mem_ack) begin
              state      <= REQ;
              mem_req_q  <= 1'b1;
              mem_addr_q <= target_pc;
            end else begin
              state <= DROP;
            end
          end else if (bus.mem_ack) begin
            fetch_pc <= next_pc;
            if (count_after < DEPTH_C) begin
              mem_addr_q <= next_pc;
            end else begin
              state     <= IDLE;
              mem_req_q <= 1'b0;
            end
          end
        end
        DROP: begin
          if (bus.redirect) fetch_pc <= target_pc;
          if (bus.mem_ack) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Testbench for ifetch (default build, IFETCH_BYPASS_EN undefined): directed
// scenarios plus a randomized run against a queue-based reference model.
module tb_ifetch;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  ifetch_if bus();

  ifetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  // Drive one cycle of inputs (ack only against a visible request) and step
  // to just after the next rising edge.
  task automatic apply_stimulus(input logic ack_en, input logic ready,
                                input logic redir, input logic [31:0] rpc);
    bus.mem_ack     = bus.mem_req & ack_en;
    bus.mem_data    = word_at(bus.mem_addr);
    bus.ir_ready    = ready;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges, then release it.
  task automatic do_reset;
    reset = 1'b1;
    bus.mem_ack = 1'b0; bus.mem_data = '0; bus.ir_ready = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_data = 32'hDEAD_BEEF; bus.ir_ready = 1'b1;
    bus.redirect = 1'b0; bus.redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_req: got %b want 0", bus.mem_req); end
    vectors++; if (bus.mem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mem_addr: got %h want 00000000", bus.mem_addr); end
    vectors++; if (bus.ir_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ir_valid: got %b want 0", bus.ir_valid); end
    vectors++; if (bus.ir !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_ir: got %h want 00000000", bus.ir); end
    vectors++; if (bus.ir_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_ir_pc: got %h want 00000000", bus.ir_pc); end
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b1, 1'b0, '0);
    vectors++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL first_req: got req=%b addr=%h want req=1 addr=00000000", bus.mem_req, bus.mem_addr); end
  endtask

  task automatic test_stream;
    do_reset();
    apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    vectors++; if (bus.ir_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_first_valid: got %b want 0", bus.ir_valid); end
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, '0);
      vectors++;
      if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 32'(4 * i) || bus.ir !== word_at(32'(4 * i))) begin
        miscompares++;
        $display("[TB] FAIL stream_%0d: got valid=%b pc=%h ir=%h want valid=1 pc=%h ir=%h", i, bus.ir_valid, bus.ir_pc, bus.ir, 32'(4 * i), word_at(32'(4 * i)));
      end
    end
  endtask

  task automatic test_backpressure;
    int acks;
    do_reset();
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_req) acks++;
      apply_stimulus(1'b1, 1'b0, 1'b0, '0);
    end
    vectors++; if (acks !== DEPTH) begin miscompares++; $display("[TB] FAIL bp_acks: got %0d want %0d", acks, DEPTH); end
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_req_stalled: got %b want 0", bus.mem_req); end
    vectors++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL bp_head: got valid=%b pc=%h want valid=1 pc=00000000", bus.ir_valid, bus.ir_pc); end
    apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    vectors++; if (bus.ir_pc !== 32'h4) begin miscompares++; $display("[TB] FAIL bp_pop1: got pc=%h want 00000004", bus.ir_pc); end
    apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    vectors++; if (bus.ir_pc !== 32'h8) begin miscompares++; $display("[TB] FAIL bp_pop2: got pc=%h want 00000008", bus.ir_pc); end
    vectors++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10) begin miscompares++; $display("[TB] FAIL bp_rereq: got req=%b addr=%h want req=1 addr=00000010", bus.mem_req, bus.mem_addr); end
    apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    vectors++; if (bus.ir_pc !== 32'hC) begin miscompares++; $display("[TB] FAIL bp_pop3: got pc=%h want 0000000c", bus.ir_pc); end
    apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    vectors++; if (bus.ir_pc !== 32'h10 || bus.ir !== word_at(32'h10)) begin miscompares++; $display("[TB] FAIL bp_pop4: got pc=%h ir=%h want pc=00000010 ir=%h", bus.ir_pc, bus.ir, word_at(32'h10)); end
  endtask

  task automatic test_redirect_drop;
    do_reset();
    apply_stimulus(1'b0, 1'b1, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h0000_1003);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0 || bus.ir_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL drop_hold_%0d: got req=%b addr=%h valid=%b want req=1 addr=00000000 valid=0", k, bus.mem_req, bus.mem_addr, bus.ir_valid);
      end
      apply_stimulus((k == 2) ? 1'b1 : 1'b0, 1'b1, 1'b0, '0);
    end
    vectors++; if (bus.mem_req !== 1'b0 || bus.ir_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_discard: got req=%b valid=%b want req=0 valid=0", bus.mem_req, bus.ir_valid); end
    apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    vectors++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_1000) begin miscompares++; $display("[TB] FAIL drop_new_addr: got req=%b addr=%h want req=1 addr=00001000", bus.mem_req, bus.mem_addr); end
    apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    vectors++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 32'h0000_1000 || bus.ir !== word_at(32'h1000)) begin miscompares++; $display("[TB] FAIL drop_first_new: got valid=%b pc=%h ir=%h want valid=1 pc=00001000", bus.ir_valid, bus.ir_pc, bus.ir); end
  endtask

  task automatic test_redirect_ack;
    do_reset();
    apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h0000_2000);
    vectors++;
    if (bus.ir_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_2000) begin
      miscompares++;
      $display("[TB] FAIL redir_ack: got valid=%b req=%b addr=%h want valid=0 req=1 addr=00002000", bus.ir_valid, bus.mem_req, bus.mem_addr);
    end
    apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    vectors++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 32'h0000_2000) begin miscompares++; $display("[TB] FAIL redir_ack_next: got valid=%b pc=%h want valid=1 pc=00002000", bus.ir_valid, bus.ir_pc); end
  endtask

  task automatic test_wrap;
    logic [31:0] seq [4];
    seq[0] = 32'hFFFF_FFF8; seq[1] = 32'hFFFF_FFFC; seq[2] = 32'h0; seq[3] = 32'h4;
    do_reset();
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== seq[i]) begin
        miscompares++;
        $display("[TB] FAIL wrap_addr_%0d: got req=%b addr=%h want req=1 addr=%h", i, bus.mem_req, bus.mem_addr, seq[i]);
      end
      apply_stimulus(1'b1, 1'b1, 1'b0, '0);
      vectors++;
      if (bus.ir_valid !== 1'b1 || bus.ir_pc !== seq[i] || bus.ir !== word_at(seq[i])) begin
        miscompares++;
        $display("[TB] FAIL wrap_ir_%0d: got valid=%b pc=%h want valid=1 pc=%h", i, bus.ir_valid, bus.ir_pc, seq[i]);
      end
    end
  endtask

  task automatic test_reset_midreq;
    do_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0, '0);
    apply_stimulus(1'b1, 1'b0, 1'b0, '0);
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, '0);
    vectors++; if (bus.mem_req !== 1'b0 || bus.ir_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midreq_reset: got req=%b valid=%b want req=0 valid=0", bus.mem_req, bus.ir_valid); end
    reset = 1'b0;
    apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    vectors++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL midreq_restart: got req=%b addr=%h want req=1 addr=00000000", bus.mem_req, bus.mem_addr); end
    apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    vectors++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL midreq_first: got valid=%b pc=%h want valid=1 pc=00000000", bus.ir_valid, bus.ir_pc); end
  endtask

  // Randomized run: the model is an in-order list of PCs the core should
  // see, plus whether the request currently in flight has been superseded.
  task automatic test_random;
    logic [31:0] mq [$];
    logic [31:0] exp_fetch;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic        stale;
    logic        ack_en, ready, redir, req, ack, pending;
    int          delivered;
    do_reset();
    exp_fetch = 32'h0;
    stale = 1'b0;
    delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      vectors++;
      if (bus.ir_valid !== (mq.size() != 0)) begin
        miscompares++;
        $display("[TB] FAIL rand_valid @%0d: got %b want %b", cyc, bus.ir_valid, (mq.size() != 0));
      end
      if (mq.size() != 0) begin
        vectors++;
        if (bus.ir_pc !== mq[0] || bus.ir !== word_at(mq[0])) begin
          miscompares++;
          $display("[TB] FAIL rand_head @%0d: got pc=%h ir=%h want pc=%h ir=%h", cyc, bus.ir_pc, bus.ir, mq[0], word_at(mq[0]));
        end
      end
      ack_en = ($urandom_range(0, 2) != 0);
      ready  = ($urandom_range(0, 3) != 0);
      redir  = ($urandom_range(0, 19) == 0);
      rpc    = $urandom;
      req    = bus.mem_req;
      addr   = bus.mem_addr;
      ack    = req & ack_en;
      if (req) begin
        vectors++;
        if (addr[1:0] !== 2'b00) begin miscompares++; $display("[TB] FAIL rand_align @%0d: got addr=%h", cyc, addr); end
      end
      if (redir) begin
        mq.delete();
        stale = req & ~ack;
        exp_fetch = rpc & ~32'h3;
      end else begin
        if (mq.size() != 0 && ready) begin
          void'(mq.pop_front());
          delivered++;
        end
        if (ack) begin
          if (stale) begin
            stale = 1'b0;
          end else begin
            vectors++;
            if (addr !== exp_fetch) begin miscompares++; $display("[TB] FAIL rand_fetch_addr @%0d: got %h want %h", cyc, addr, exp_fetch); end
            mq.push_back(exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
          end
        end
      end
      pending = req & ~ack;
      apply_stimulus(ack_en, ready, redir, rpc);
      if (pending) begin
        vectors++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== addr) begin
          miscompares++;
          $display("[TB] FAIL rand_hold @%0d: got req=%b addr=%h want req=1 addr=%h", cyc, bus.mem_req, bus.mem_addr, addr);
        end
      end
    end
    vectors++;
    if (delivered < 100) begin miscompares++; $display("[TB] FAIL rand_progress: got %0d delivered want at least 100", delivered); end
  endtask

  initial begin
    reset = 1'b1;
    bus.mem_ack = 1'b0; bus.mem_data = '0; bus.ir_ready = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_ack();
    test_wrap();
    test_reset_midreq();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
